dmem_wt_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache that answers the MEM stage's data-memory requests. It accepts word-aligned read/write requests with byte enables and returns `dmem_resp`/`dmem_rdata`. Misses and all writes go to a 32-bit physical-memory port that has a request/response handshake. It sits between the MEM stage and the memory arbiter, replacing the direct dmem connection.

---
 rtl/dmem_wt_cache.sv | 157 +++++++++++++++
 tb/tb_dmem_wt_cache.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wt_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM stage
// and the physical-memory port. One 32-bit word per line, valid bits in flops, tag/data in RAM.
module dmem_wt_cache #(
   parameter int SETS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dmem_address,
   input  logic        dmem_read,
   input  logic        dmem_write,
   input  logic [3:0]  mem_byte_enable,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic [31:0] pmem_address,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic [3:0]  pmem_byte_enable,
   output logic [31:0] pmem_wdata,
   input  logic [31:0] pmem_rdata,
   input  logic        pmem_resp
);

   localparam int IDX   = $clog2(SETS);
   localparam int TAG_W = 30 - IDX;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_FETCH,
      S_WRITE,
      S_DONE
   } state_t;

   state_t            state_reg;
   logic [SETS-1:0]   valid_reg;
   logic              hit_reg;
   logic [31:0]       fill_word_reg;

   logic [31:0]       data_mem [SETS];
   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [31:0]       data_q;
   logic [TAG_W-1:0]  tag_q;

   logic [IDX-1:0]    idx;
   logic [TAG_W-1:0]  addr_tag;
   logic              is_read;
   logic              is_write;
   logic              hit;
   logic              fill_we;
   logic              merge_we;
   logic [31:0]       merged_word;
   logic              unused_addr_bits;

   assign idx              = dmem_address[2 +: IDX];
   assign addr_tag         = dmem_address[31 -: TAG_W];
   assign unused_addr_bits = ^dmem_address[1:0];

   // A simultaneous read+write is handled as a write.
   assign is_write = dmem_write;
   assign is_read  = dmem_read & ~dmem_write;

   // tag_q/data_q are the registered RAM read taken in IDLE; the request is held stable after that.
   assign hit      = valid_reg[idx] && (tag_q == addr_tag);
   assign fill_we  = ~rst && (state_reg == S_FETCH) && pmem_resp;
   assign merge_we = ~rst && (state_reg == S_WRITE) && pmem_resp && hit_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign merged_word[8*gi +: 8] = mem_byte_enable[gi] ? dmem_wdata[8*gi +: 8]
                                                             : data_q[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (fill_we) begin
         data_mem[idx] <= pmem_rdata;
         tag_mem[idx]  <= addr_tag;
      end else if (merge_we) begin
         data_mem[idx] <= merged_word;
      end
      if (state_reg == S_IDLE) begin
         data_q <= data_mem[idx];
         tag_q  <= tag_mem[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         valid_reg     <= '0;
         hit_reg       <= 1'b0;
         fill_word_reg <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (dmem_read || dmem_write) state_reg <= S_LOOKUP;
            end
            S_LOOKUP: begin
               hit_reg <= hit;
               if (is_write)     state_reg <= S_WRITE;
               else if (!is_read) state_reg <= S_IDLE;
               else if (hit)     state_reg <= S_IDLE;
               else              state_reg <= S_FETCH;
            end
            S_FETCH: begin
               if (pmem_resp) begin
                  valid_reg[idx] <= 1'b1;
                  fill_word_reg  <= pmem_rdata;
                  state_reg      <= S_DONE;
               end
            end
            S_WRITE: begin
               if (pmem_resp) state_reg <= S_DONE;
            end
            S_DONE:  state_reg <= S_IDLE;
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Outputs decode the state register; idle values are all zero.
   always_comb begin
      dmem_resp        = 1'b0;
      dmem_rdata       = '0;
      pmem_read        = 1'b0;
      pmem_write       = 1'b0;
      pmem_address     = '0;
      pmem_byte_enable = '0;
      pmem_wdata       = '0;
      case (state_reg)
         S_LOOKUP: begin
            if (is_read && hit) begin
               dmem_resp  = 1'b1;
               dmem_rdata = data_q;
            end
         end
         S_FETCH: begin
            pmem_read    = 1'b1;
            pmem_address = {dmem_address[31:2], 2'b00};
         end
         S_WRITE: begin
            pmem_write       = 1'b1;
            pmem_address     = {dmem_address[31:2], 2'b00};
            pmem_byte_enable = mem_byte_enable;
            pmem_wdata       = dmem_wdata;
         end
         S_DONE: begin
            dmem_resp = 1'b1;
            if (is_read) dmem_rdata = fill_word_reg;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dmem_wt_cache.sv
// Scoreboard bench for dmem_wt_cache: directed requests push expected dmem and pmem
// responses; independent monitors pop and compare when the DUT presents them.
`timescale 1ns/1ps
module tb_dmem_wt_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dmem_address;
   logic        dmem_read;
   logic        dmem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic [31:0] pmem_address;
   logic        pmem_read;
   logic        pmem_write;
   logic [3:0]  pmem_byte_enable;
   logic [31:0] pmem_wdata;
   logic [31:0] pmem_rdata;
   logic        pmem_resp;

   dmem_wt_cache #(.SETS(16)) dut (
      .clk              (clk),
      .rst              (rst),
      .dmem_address     (dmem_address),
      .dmem_read        (dmem_read),
      .dmem_write       (dmem_write),
      .mem_byte_enable  (mem_byte_enable),
      .dmem_wdata       (dmem_wdata),
      .dmem_rdata       (dmem_rdata),
      .dmem_resp        (dmem_resp),
      .pmem_address     (pmem_address),
      .pmem_read        (pmem_read),
      .pmem_write       (pmem_write),
      .pmem_byte_enable (pmem_byte_enable),
      .pmem_wdata       (pmem_wdata),
      .pmem_rdata       (pmem_rdata),
      .pmem_resp        (pmem_resp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } pm_t;

   exp_t sb_q[$];
   pm_t  pm_q[$];

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   req_cyc = 0;
   int   resp_delay = 1;
   int   resp_cnt = 0;
   bit   mon_en = 0;

   logic [31:0] mem_model [int unsigned];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // dmem response monitor
   exp_t e_mon;
   logic resp_prev = 1'b0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (dmem_resp) begin
            resp_cnt++;
            check32("resp_not_back_to_back", {31'd0, resp_prev}, 32'd0);
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_dmem_resp: got rdata 0x%08h expected no response", dmem_rdata);
            end else begin
               e_mon = sb_q.pop_front();
               check32("dmem_rdata", dmem_rdata, e_mon.rdata);
               check32("resp_latency", 32'(cyc - req_cyc), 32'(e_mon.lat));
               $display("[TB] resp cycle %0d rdata 0x%08h latency %0d", cyc, dmem_rdata, cyc - req_cyc);
            end
         end else begin
            check32("rdata_zero_without_resp", dmem_rdata, 32'd0);
         end
      end
      resp_prev = dmem_resp;
   end

   // pmem request monitor: compares each new transaction when it starts
   pm_t  p_mon;
   logic pm_prev = 1'b0;
   always @(negedge clk) begin
      if (mon_en) begin
         if ((pmem_read || pmem_write) && !pm_prev) begin
            if (pm_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_pmem_txn: got rd=%0b wr=%0b addr 0x%08h expected none",
                        pmem_read, pmem_write, pmem_address);
            end else begin
               p_mon = pm_q.pop_front();
               check32("pmem_read", {31'd0, pmem_read}, {31'd0, p_mon.rd});
               check32("pmem_write", {31'd0, pmem_write}, {31'd0, p_mon.wr});
               check32("pmem_address", pmem_address, p_mon.addr);
               check32("pmem_byte_enable", {28'd0, pmem_byte_enable}, {28'd0, p_mon.be});
               check32("pmem_wdata", pmem_wdata, p_mon.wdata);
            end
         end else if (!(pmem_read || pmem_write)) begin
            check32("pmem_idle_zero", {pmem_address[31:4], pmem_address[3:0] | pmem_byte_enable},
                    32'd0);
            check32("pmem_wdata_idle_zero", pmem_wdata, 32'd0);
         end
      end
      pm_prev = pmem_read || pmem_write;
   end

   // Physical memory responder: resp_delay cycles after a request is first seen
   int          r_d;
   logic        r_wr;
   logic [31:0] r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [31:0] r_word;
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if ((pmem_read || pmem_write) && !rst) begin
            r_d     = resp_delay;
            r_wr    = pmem_write;
            r_addr  = pmem_address;
            r_be    = pmem_byte_enable;
            r_wdata = pmem_wdata;
            repeat (r_d) @(negedge clk);
            r_word = mem_model.exists(r_addr) ? mem_model[r_addr] : 32'd0;
            if (r_wr) begin
               for (int b = 0; b < 4; b++)
                  if (r_be[b]) r_word[8*b +: 8] = r_wdata[8*b +: 8];
               mem_model[r_addr] = r_word;
            end else begin
               pmem_rdata = r_word;
            end
            pmem_resp = 1'b1;
            @(negedge clk);
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
         end
      end
   end

   // pm: 0 = no pmem traffic expected, 1 = read, 2 = write
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input int d,
                         input logic [31:0] exp_rdata, input int exp_lat, input int pm);
      exp_t e;
      pm_t  p;
      bit   seen;
      e.rdata = exp_rdata;
      e.lat   = exp_lat;
      sb_q.push_back(e);
      if (pm != 0) begin
         p.rd    = (pm == 1);
         p.wr    = (pm == 2);
         p.addr  = {addr[31:2], 2'b00};
         p.be    = (pm == 2) ? be : 4'd0;
         p.wdata = (pm == 2) ? wd : 32'd0;
         pm_q.push_back(p);
      end
      resp_delay = d;
      @(posedge clk);
      #1;
      dmem_read       = rd;
      dmem_write      = wr;
      dmem_address    = addr;
      mem_byte_enable = be;
      dmem_wdata      = wd;
      req_cyc         = cyc;
      $display("[TB] req cycle %0d rd=%0b wr=%0b addr 0x%08h be %04b wdata 0x%08h",
               cyc, rd, wr, addr, be, wd);
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (dmem_resp) seen = 1;
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL req_timeout: got no dmem_resp expected one within 40 cycles, addr 0x%08h", addr);
      end
      @(posedge clk);
      #1;
      dmem_read       = 1'b0;
      dmem_write      = 1'b0;
      mem_byte_enable = '0;
      dmem_wdata      = '0;
   endtask

   task automatic abort_fetch(input logic [31:0] addr);
      pm_t p;
      bit  seen;
      int  resp_before;
      p.rd = 1'b1; p.wr = 1'b0; p.addr = addr; p.be = '0; p.wdata = '0;
      pm_q.push_back(p);
      resp_delay = 4;
      @(posedge clk);
      #1;
      dmem_read    = 1'b1;
      dmem_address = addr;
      $display("[TB] req cycle %0d read 0x%08h to be aborted by reset", cyc, addr);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (pmem_read) seen = 1;
      end
      check32("abort_fetch_started", {31'd0, seen}, 32'd1);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      dmem_read = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      resp_before = resp_cnt;
      @(negedge clk);
      check32("abort_pmem_read_low", {31'd0, pmem_read}, 32'd0);
      check32("abort_pmem_write_low", {31'd0, pmem_write}, 32'd0);
      repeat (8) @(negedge clk);
      check32("abort_no_dmem_resp", 32'(resp_cnt - resp_before), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion expected finish before 200us");
      $fatal(1, "timeout");
   end

   initial begin
      mem_model[32'h40]  = 32'hDEADBEEF;
      mem_model[32'h44]  = 32'h55667788;
      mem_model[32'h80]  = 32'hCAFEF00D;
      mem_model[32'h100] = 32'h0BADF00D;
      mem_model[32'h440] = 32'h12345678;

      rst             = 1'b1;
      dmem_address    = '0;
      dmem_read       = 1'b0;
      dmem_write      = 1'b0;
      mem_byte_enable = '0;
      dmem_wdata      = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check32("reset_dmem_resp", {31'd0, dmem_resp}, 32'd0);
      check32("reset_dmem_rdata", dmem_rdata, 32'd0);
      check32("reset_pmem_read", {31'd0, pmem_read}, 32'd0);
      check32("reset_pmem_write", {31'd0, pmem_write}, 32'd0);
      check32("reset_pmem_address", pmem_address, 32'd0);
      check32("reset_pmem_byte_enable", {28'd0, pmem_byte_enable}, 32'd0);
      check32("reset_pmem_wdata", pmem_wdata, 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      //      rd  wr  addr         be       wdata         d  exp_rdata     lat pm
      do_req(1, 0, 32'h40,  4'b0000, 32'h0,        3, 32'hDEADBEEF, 6, 1);
      do_req(1, 0, 32'h40,  4'b0000, 32'h0,        0, 32'hDEADBEEF, 1, 0);
      do_req(1, 0, 32'h44,  4'b0000, 32'h0,        1, 32'h55667788, 4, 1);
      do_req(1, 0, 32'h40,  4'b0000, 32'h0,        0, 32'hDEADBEEF, 1, 0);
      do_req(0, 1, 32'h40,  4'b0100, 32'h00AA0000, 0, 32'h0,        3, 2);
      do_req(1, 0, 32'h40,  4'b0000, 32'h0,        0, 32'hDEAABEEF, 1, 0);
      do_req(0, 1, 32'h80,  4'b1111, 32'h11223344, 1, 32'h0,        4, 2);
      do_req(1, 0, 32'h80,  4'b0000, 32'h0,        2, 32'h11223344, 5, 1);
      do_req(1, 0, 32'h80,  4'b0000, 32'h0,        0, 32'h11223344, 1, 0);
      do_req(1, 0, 32'h440, 4'b0000, 32'h0,        1, 32'h12345678, 4, 1);
      do_req(1, 0, 32'h40,  4'b0000, 32'h0,        1, 32'hDEAABEEF, 4, 1);
      do_req(1, 0, 32'h440, 4'b0000, 32'h0,        1, 32'h12345678, 4, 1);
      do_req(0, 1, 32'h440, 4'b0000, 32'hFFFFFFFF, 1, 32'h0,        4, 2);
      do_req(1, 0, 32'h440, 4'b0000, 32'h0,        0, 32'h12345678, 1, 0);
      do_req(0, 1, 32'h440, 4'b1001, 32'hAA0000BB, 2, 32'h0,        5, 2);
      do_req(1, 0, 32'h440, 4'b0000, 32'h0,        0, 32'hAA3456BB, 1, 0);
      do_req(1, 1, 32'h40,  4'b0001, 32'h000000AB, 1, 32'h0,        4, 2);
      do_req(1, 0, 32'h40,  4'b0000, 32'h0,        1, 32'hDEAABEAB, 4, 1);
      do_req(1, 0, 32'h44,  4'b0000, 32'h0,        0, 32'h55667788, 1, 0);

      abort_fetch(32'h100);

      do_req(1, 0, 32'h40,  4'b0000, 32'h0,        1, 32'hDEAABEAB, 4, 1);
      do_req(1, 0, 32'h44,  4'b0000, 32'h0,        0, 32'h55667788, 3, 1);

      repeat (4) @(negedge clk);
      check32("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      check32("pmem_queue_drained", 32'(pm_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
